// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with parity/framing checks, break handling and a running checksum
// Ports: clk, rst (sync, active-high); i_serial async line (idle high);
//        o_data/o_valid/o_parity_err/o_frame_err frame result strobe; o_sum checksum of good payloads; o_idle line idle.
module uart_rx_cfg #(
  parameter int cycles_per_bit = 3,
  parameter int data_bits      = 8,
  parameter int parity_mode    = 0,
  parameter int stop_bits      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_serial,
  output logic [data_bits-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic [31:0]          o_sum,
  output logic                 o_idle
);
  localparam int HALF = (cycles_per_bit - 1) / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [data_bits-1:0] shift_q, shift_d, data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 valid_q, valid_d, operr_q, operr_d, oferr_q, oferr_d;
  logic [31:0]          sum_q, sum_d;
  logic                 rx_s, tick;
  assign rx_s = sync_q[1];
  assign tick = cnt_q == 16'(cycles_per_bit - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    operr_d = operr_q;
    oferr_d = oferr_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        idx_d   = '0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == 16'(HALF)) begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[data_bits-1:1]};
        idx_d   = idx_q + 4'd1;
        if (idx_q == 4'(data_bits - 1)) begin
          idx_d   = '0;
          state_d = (parity_mode != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        cnt_d   = '0;
        // odd mode expects the payload+parity XOR to be 1, even mode expects 0
        perr_d  = (^shift_q ^ rx_s) != (parity_mode == 1);
        state_d = STOP;
      end
      STOP: if (tick) begin
        cnt_d  = '0;
        ferr_d = ferr_q | ~rx_s;
        idx_d  = idx_q + 4'd1;
        if (idx_q == 4'(stop_bits - 1)) begin
          valid_d = 1'b1;
          data_d  = shift_q;
          operr_d = perr_q;
          oferr_d = ferr_d;
          sum_d   = (!perr_q && !ferr_d) ? sum_q + 32'(shift_q) : sum_q;
          // a line still low after a bad stop is a break: park until it rises
          state_d = (ferr_d && !rx_s) ? BREAK : IDLE;
        end
      end
      BREAK: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], i_serial};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
      sum_q   <= sum_d;
    end
  end
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = operr_q;
  assign o_frame_err  = oferr_q;
  assign o_sum        = sum_q;
  assign o_idle       = (state_q == IDLE) && rx_s;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receiver configurations driven with directed and random frames against a frame-level model
module tb_uart_rx_cfg;
  localparam int CPB [3] = '{3, 3, 16};
  localparam int NB  [3] = '{8, 8, 9};
  localparam int PM  [3] = '{0, 2, 1};
  localparam int SB  [3] = '{1, 1, 2};
  typedef struct packed {
    logic [1:0]  k;
    logic [8:0]  d;
    logic        pe;
    logic        fe;
    logic [31:0] s;
  } ev_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        ser [3];
  logic [7:0]  d0, d1;
  logic [8:0]  d2;
  logic [8:0]  dat [3];
  logic        vld [3], pe [3], fe [3], idl [3];
  logic [31:0] sum [3];
  logic [31:0] exp_sum [3];
  ev_t         evq [$];
  ev_t         exq [$];
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  uart_rx_cfg #(.cycles_per_bit(3), .data_bits(8), .parity_mode(0), .stop_bits(1)) u0 (
    .clk(clk), .rst(rst), .i_serial(ser[0]), .o_data(d0), .o_valid(vld[0]), .o_parity_err(pe[0]),
    .o_frame_err(fe[0]), .o_sum(sum[0]), .o_idle(idl[0]));
  uart_rx_cfg #(.cycles_per_bit(3), .data_bits(8), .parity_mode(2), .stop_bits(1)) u1 (
    .clk(clk), .rst(rst), .i_serial(ser[1]), .o_data(d1), .o_valid(vld[1]), .o_parity_err(pe[1]),
    .o_frame_err(fe[1]), .o_sum(sum[1]), .o_idle(idl[1]));
  uart_rx_cfg #(.cycles_per_bit(16), .data_bits(9), .parity_mode(1), .stop_bits(2)) u2 (
    .clk(clk), .rst(rst), .i_serial(ser[2]), .o_data(d2), .o_valid(vld[2]), .o_parity_err(pe[2]),
    .o_frame_err(fe[2]), .o_sum(sum[2]), .o_idle(idl[2]));
  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = d2;
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (vld[k] === 1'b1) evq.push_back(ev_t'{k: 2'(k), d: dat[k], pe: pe[k], fe: fe[k], s: sum[k]});
  function automatic string fmt(ev_t e);
    return $sformatf("k=%0d d=%h pe=%b fe=%b sum=%h", e.k, e.d, e.pe, e.fe, e.s);
  endfunction
  function automatic ev_t model(int k, logic [8:0] d, logic p, logic [1:0] st);
    logic [8:0] dd;
    logic       x, perr, ferr;
    dd   = d & 9'((1 << NB[k]) - 1);
    x    = ^dd ^ p;
    perr = PM[k] == 1 ? x != 1'b1 : PM[k] == 2 ? x != 1'b0 : 1'b0;
    ferr = !st[0] || (SB[k] == 2 && !st[1]);
    if (!perr && !ferr) exp_sum[k] = exp_sum[k] + 32'(dd);
    return ev_t'{k: 2'(k), d: dd, pe: perr, fe: ferr, s: exp_sum[k]};
  endfunction
  task automatic bitx(int k, logic b);
    ser[k] = b;
    repeat (CPB[k]) @(negedge clk);
  endtask
  task automatic send(int k, logic [8:0] d, logic p, logic [1:0] st);
    bitx(k, 1'b0);
    for (int i = 0; i < NB[k]; i++) bitx(k, d[i]);
    if (PM[k] != 0) bitx(k, p);
    for (int j = 0; j < SB[k]; j++) bitx(k, st[j]);
  endtask
  task automatic test_reset;
    for (int k = 0; k < 3; k++) ser[k] = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dat[k], vld[k], pe[k], fe[k], sum[k], idl[k]} !== {9'd0, 3'b000, 32'd0, 1'b1}) begin
        failures++;
        $display("FAIL reset[%0d] got d=%h v=%b pe=%b fe=%b sum=%h idle=%b exp zeros idle=1",
                 k, dat[k], vld[k], pe[k], fe[k], sum[k], idl[k]);
      end
      exp_sum[k] = '0;
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_basic;
    evq.delete(); exq.delete();
    exq.push_back(model(0, 9'h48, 1'b0, 2'b11));
    exq.push_back(model(0, 9'h69, 1'b0, 2'b11));
    send(0, 9'h48, 1'b0, 2'b11);
    send(0, 9'h69, 1'b0, 2'b11);
    repeat (12) @(negedge clk);
    checks++;
    if (evq.size() != exq.size()) begin failures++; $display("FAIL basic_count got %0d exp %0d", evq.size(), exq.size()); end
    for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
      checks++;
      if (evq[i] !== exq[i]) begin failures++; $display("FAIL basic[%0d] got %s exp %s", i, fmt(evq[i]), fmt(exq[i])); end
    end
    checks++;
    if (sum[0] !== 32'hB1 || idl[0] !== 1'b1) begin
      failures++; $display("FAIL basic_end got sum=%h idle=%b exp sum=000000b1 idle=1", sum[0], idl[0]);
    end
  endtask
  task automatic test_parity;
    evq.delete(); exq.delete();
    exq.push_back(model(1, 9'h48, 1'b0, 2'b11));
    exq.push_back(model(1, 9'h48, 1'b1, 2'b11));
    send(1, 9'h48, 1'b0, 2'b11);
    send(1, 9'h48, 1'b1, 2'b11);
    repeat (12) @(negedge clk);
    checks++;
    if (evq.size() != exq.size()) begin failures++; $display("FAIL parity_count got %0d exp %0d", evq.size(), exq.size()); end
    for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
      checks++;
      if (evq[i] !== exq[i]) begin failures++; $display("FAIL parity[%0d] got %s exp %s", i, fmt(evq[i]), fmt(exq[i])); end
    end
  endtask
  task automatic test_glitch;
    evq.delete();
    ser[0] = 1'b0;
    @(negedge clk);
    ser[0] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (evq.size() != 0 || idl[0] !== 1'b1 || sum[0] !== exp_sum[0]) begin
      failures++;
      $display("FAIL glitch got strobes=%0d idle=%b sum=%h exp strobes=0 idle=1 sum=%h", evq.size(), idl[0], sum[0], exp_sum[0]);
    end
  endtask
  task automatic test_break;
    logic [8:0] d;
    evq.delete(); exq.delete();
    d = 9'($urandom);
    exq.push_back(model(0, d, 1'b0, 2'b00));
    send(0, d, 1'b0, 2'b00);
    repeat (40) @(negedge clk);
    checks++;
    if (idl[0] !== 1'b0 || evq.size() != 1) begin
      failures++; $display("FAIL break_hold got idle=%b strobes=%0d exp idle=0 strobes=1", idl[0], evq.size());
    end
    bitx(0, 1'b1);
    bitx(0, 1'b1);
    exq.push_back(model(0, 9'h55, 1'b0, 2'b11));
    send(0, 9'h55, 1'b0, 2'b11);
    repeat (12) @(negedge clk);
    checks++;
    if (evq.size() != exq.size()) begin failures++; $display("FAIL break_count got %0d exp %0d", evq.size(), exq.size()); end
    for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
      checks++;
      if (evq[i] !== exq[i]) begin failures++; $display("FAIL break[%0d] got %s exp %s", i, fmt(evq[i]), fmt(exq[i])); end
    end
  endtask
  task automatic test_reset_mid;
    logic [8:0] d;
    evq.delete(); exq.delete();
    d = 9'($urandom);
    bitx(0, 1'b0);
    for (int i = 0; i < 4; i++) bitx(0, d[i]);
    ser[0] = d[4];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) ser[k] = 1'b1;
    @(negedge clk);
    checks++;
    if ({dat[0], vld[0], pe[0], fe[0], sum[0], idl[0]} !== {9'd0, 3'b000, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid got d=%h v=%b pe=%b fe=%b sum=%h idle=%b exp zeros idle=1",
               dat[0], vld[0], pe[0], fe[0], sum[0], idl[0]);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) exp_sum[k] = '0;
    repeat (40) @(negedge clk);
    exq.push_back(model(0, 9'hA5, 1'b0, 2'b11));
    send(0, 9'hA5, 1'b0, 2'b11);
    repeat (12) @(negedge clk);
    checks++;
    if (evq.size() != exq.size()) begin failures++; $display("FAIL reset_mid_count got %0d exp %0d", evq.size(), exq.size()); end
    for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
      checks++;
      if (evq[i] !== exq[i]) begin failures++; $display("FAIL reset_mid[%0d] got %s exp %s", i, fmt(evq[i]), fmt(exq[i])); end
    end
    checks++;
    if (sum[0] !== 32'hA5) begin failures++; $display("FAIL reset_mid_sum got %h exp 000000a5", sum[0]); end
  endtask
  task automatic test_wide;
    logic [8:0] d;
    evq.delete(); exq.delete();
    exq.push_back(model(2, 9'h1FF, 1'b0, 2'b11));
    send(2, 9'h1FF, 1'b0, 2'b11);
    d = 9'($urandom);
    exq.push_back(model(2, d, ^d, 2'b01));
    send(2, d, ^d, 2'b01);
    bitx(2, 1'b1);
    repeat (40) @(negedge clk);
    checks++;
    if (evq.size() != exq.size()) begin failures++; $display("FAIL wide_count got %0d exp %0d", evq.size(), exq.size()); end
    for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
      checks++;
      if (evq[i] !== exq[i]) begin failures++; $display("FAIL wide[%0d] got %s exp %s", i, fmt(evq[i]), fmt(exq[i])); end
    end
    checks++;
    if (sum[2] !== 32'h1FF) begin failures++; $display("FAIL wide_sum got %h exp 000001ff", sum[2]); end
  endtask
  task automatic test_random;
    logic [8:0] d;
    logic       p;
    logic [1:0] st;
    for (int k = 0; k < 3; k++) begin
      evq.delete(); exq.delete();
      repeat (8) begin
        d  = 9'($urandom);
        p  = 1'($urandom);
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        exq.push_back(model(k, d, p, st));
        send(k, d, p, st);
        if (!ser[k]) bitx(k, 1'b1);
      end
      repeat (4 * CPB[k]) @(negedge clk);
      checks++;
      if (evq.size() != exq.size()) begin failures++; $display("FAIL random_count[%0d] got %0d exp %0d", k, evq.size(), exq.size()); end
      for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
        checks++;
        if (evq[i] !== exq[i]) begin failures++; $display("FAIL random[%0d] got %s exp %s", i, fmt(evq[i]), fmt(exq[i])); end
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) ser[k] = 1'b1;
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_break;
    test_reset_mid;
    test_wide;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver; successor to the fixed-format receive path in uart_top.
- Width, oversample rate, parity mode and stop-bit count are configurable.
- Flags parity and framing errors, handles line breaks, and keeps a running checksum of good bytes.
- Sits beside uart_tx in uart_top; its checksum output drives the top-level pass/fail compare.

Parameters:
- cycles_per_bit, 3: clocks per serial bit; legal range 3..65535.
- data_bits, 8: payload bits per frame, LSB first; legal range 5..9.
- parity_mode, 0: 0 = none, 1 = odd, 2 = even.
- stop_bits, 1: number of stop bits checked, 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_serial  in  1  asynchronous serial line; idle high
- o_data  out  data_bits  last received payload
- o_valid  out  1  one-cycle strobe: o_data and error flags are updated
- o_parity_err  out  1  parity of the last frame was wrong; valid with o_valid
- o_frame_err  out  1  a stop bit of the last frame sampled low; valid with o_valid
- o_sum  out  32  running sum of error-free payloads, mod 2^32
- o_idle  out  1  high in IDLE with the synchronised line high

Behaviour:
- Synchroniser: i_serial passes through two flops giving rx_s (2-cycle latency). All timing below refers to rx_s.
- Reset: synchronous while rst=1, checked before all other logic.
  - FSM goes to IDLE.
  - Synchroniser flops preset to 1.
  - o_data, o_valid, both error flags and o_sum go to 0; o_idle goes to 1.
- Reset mid-frame abandons the frame with no o_valid.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rx_s=0 -> START with counter cleared.
  - START: count to HALF=(cycles_per_bit-1)/2.
    - rx_s still 0 -> DATA with counter cleared.
    - rx_s=1 -> IDLE (glitch rejected, no output).
  - DATA: sample rx_s each time counter reaches cycles_per_bit-1, then clear the counter. Bits shift in LSB first.
    - After data_bits samples -> PARITY if parity_mode!=0, else STOP.
  - PARITY: one bit period, one sample.
    - Odd mode: error if XOR(payload, parity bit) != 1.
    - Even mode: error if that XOR != 0.
  - STOP: stop_bits bit periods, one sample each; any low sample sets the frame error.
    - On the cycle after the final stop sample:
      - pulse o_valid for exactly one cycle;
      - load o_data and both error flags;
      - add o_data zero-extended to 32 bits into o_sum, only if both errors are 0.
    - Next state: frame error and rx_s=0 -> BREAK, else IDLE.
  - BREAK: wait for rx_s=1, then IDLE. A held-low line yields exactly one framing-error strobe, not repeated frames.
- Flag persistence: o_data and error flags hold between strobes. o_sum holds except on a good strobe.
- Back-to-back frames: a start edge on the cycle right after the final stop sample is accepted. The IDLE check happens in the same cycle as the o_valid pulse, with no dead cycle.
- Frame latency: last stop-bit sample to o_valid = 1 cycle.
- Count per frame: exactly one o_valid per accepted start bit, none for rejected glitches.
- o_sum overflow wraps silently.
- o_idle is low in every state except IDLE.

Test Plan:
- Basic frame: cycles_per_bit=3, data_bits=8, parity 0, stop 1. Send 0x48 then 0x69 back-to-back -> two o_valid strobes, o_data 0x48 then 0x69, no errors, o_sum=0x000000B1, o_idle=1 at the end.
- Even parity: parity_mode=2. Send 0x48 with parity bit 0 -> no error, sum +0x48. Resend with parity bit 1 -> o_parity_err=1, o_sum unchanged.
- Framing error and break: drive stop bit low, then hold the line low for 40 cycles -> one o_valid with o_frame_err=1. FSM stays in BREAK until the line rises, then 0x55 is received cleanly.
- Glitch rejection: 1-cycle low pulse on i_serial -> no o_valid, o_idle returns to 1, o_sum unchanged.
- Reset mid-frame: assert rst during DATA bit 4 -> next cycle all outputs at reset values. A following 0xA5 frame is received correctly with o_sum=0xA5.
- Wide/slow config: data_bits=9, stop_bits=2, cycles_per_bit=16, odd parity. Send 0x1FF with parity bit 0 -> o_data=0x1FF, no errors, o_sum=0x1FF. A second stop bit sampled low -> o_frame_err=1.
